// File: rtl/iecdrv_rom_sched.sv
// Shares one drive-ROM read port among NDR emulated 1541 drives, one slot per clk after each ph2_f.
// Optional IECDRV_SKIP_IDLE_EN: issue only the slots whose drive was enabled when ph2_f arrived.
module iecdrv_rom_sched #(
    parameter int NDR    = 4,
    parameter int AW     = 15,
    parameter int DW     = 8,
    parameter int RD_LAT = 1
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              ph2_f,
    input  logic [1:0]        rom_sz,
    input  logic              stdrom,
    input  logic [NDR-1:0]    drv_en,
    input  logic [NDR*AW-1:0] drv_addr,
    input  logic [DW-1:0]     rom_q,
    output logic [AW-1:0]     mem_a,
    output logic              mem_rd,
    output logic [NDR*DW-1:0] drv_data,
    output logic [NDR-1:0]    drv_vld,
    output logic              busy,
    output logic              overrun,
    input  logic              ovr_clr
);
    localparam int SW = (NDR > 1) ? $clog2(NDR) : 1;

    typedef enum logic [1:0] {IDLE, ISSUE, DRAIN} state_t;

    state_t                     state, state_nxt;
    logic [NDR-1:0][AW-1:0]     snap;
    logic [NDR-1:0]             en_snap;
    logic [SW-1:0]              slot, slot_first, slot_nxt;
    logic [1:0]                 tag;
    logic [RD_LAT-1:0]          vld_pipe;
    logic [RD_LAT-1:0][SW-1:0]  slot_pipe;
    logic [RD_LAT-1:0][1:0]     tag_pipe;
    logic                       any_en, last_slot, load, issue, capture;
    logic [AW-1:0]              a_sel, a_mask;

`ifdef IECDRV_SKIP_IDLE_EN
    // Lowest enabled drive index >= from; MSB flags that one exists.
    function automatic logic [SW:0] find_en(input logic [NDR-1:0] en, input int from);
        find_en = '0;
        for (int i = NDR - 1; i >= 0; i--)
            if (en[i] && i >= from) find_en = {1'b1, SW'(i)};
    endfunction

    logic [SW:0] f_first, f_nxt;
    assign f_first    = find_en(drv_en, 0);
    assign f_nxt      = find_en(en_snap, int'(slot) + 1);
    assign any_en     = f_first[SW];
    assign slot_first = f_first[SW-1:0];
    assign slot_nxt   = f_nxt[SW-1:0];
    assign last_slot  = !f_nxt[SW];
`else
    assign any_en     = 1'b1;
    assign slot_first = '0;
    assign slot_nxt   = slot + SW'(1);
    assign last_slot  = (slot == SW'(NDR - 1));
`endif

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state <= IDLE;
        else          state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (ph2_f && any_en) state_nxt = ISSUE;
            ISSUE:   if (ph2_f)           state_nxt = any_en ? ISSUE : DRAIN;
                     else if (last_slot)  state_nxt = DRAIN;
            DRAIN:   if (ph2_f)           state_nxt = any_en ? ISSUE : DRAIN;
                     else if (vld_pipe == '0) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // A ph2_f restart takes the place of that cycle's issue and kills any capture on the same edge.
    always_comb begin
        load       = ph2_f && (state != IDLE || any_en);
        issue      = (state == ISSUE) && !ph2_f;
        capture    = vld_pipe[RD_LAT-1] && (tag_pipe[RD_LAT-1] == tag)
                     && en_snap[slot_pipe[RD_LAT-1]] && !load;
        a_sel      = snap[slot];
        a_mask     = a_sel;
        a_mask[14] = a_sel[14] & rom_sz[1];
        a_mask[13] = a_sel[13] & (rom_sz[0] | stdrom);
    end

    assign busy = (state != IDLE);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            mem_a     <= '0;
            mem_rd    <= 1'b0;
            drv_data  <= '1;
            drv_vld   <= '0;
            overrun   <= 1'b0;
            snap      <= '0;
            en_snap   <= '0;
            slot      <= '0;
            tag       <= '0;
            vld_pipe  <= '0;
            slot_pipe <= '0;
            tag_pipe  <= '0;
        end else begin
            mem_rd <= issue;
            if (issue) mem_a <= a_mask;

            vld_pipe[0]  <= issue;
            slot_pipe[0] <= slot;
            tag_pipe[0]  <= tag;
            for (int k = 1; k < RD_LAT; k++) begin
                vld_pipe[k]  <= vld_pipe[k-1];
                slot_pipe[k] <= slot_pipe[k-1];
                tag_pipe[k]  <= tag_pipe[k-1];
            end

            if (load) begin
                snap    <= drv_addr;
                en_snap <= drv_en;
                slot    <= slot_first;
                tag     <= tag + 2'd1;
            end else if (issue) begin
                slot <= slot_nxt;
            end

            if (ph2_f && state != IDLE) overrun <= 1'b1;
            else if (ovr_clr)           overrun <= 1'b0;

            drv_vld <= '0;
            if (capture) begin
                drv_data[slot_pipe[RD_LAT-1]*DW +: DW] <= rom_q;
                drv_vld[slot_pipe[RD_LAT-1]]          <= 1'b1;
            end
        end
    end
endmodule

// File: doc/iecdrv_rom_sched.md
Name: iecdrv_rom_sched

Overview:
Time-multiplexed scheduler that lets up to four emulated 1541 drives share one drive-ROM read port in the clk domain.
- On every ph2_f strobe it snapshots each drive's ROM address and issues one masked read per drive in slot order.
- It captures the returned bytes after the ROM read latency and hands each drive its byte with a valid pulse.
- It sits between the per-drive CPU address buses and the shared ROM's clk-side port inside the multi-drive wrapper.

Parameters:
NDR, 4, number of drives served (1..4).
AW, 15, ROM address width.
DW, 8, ROM data width.
RD_LAT, 1, ROM port read latency in clk cycles from mem_a register to valid rom_q (1..3).

Ports:
clk  in  1  core clock (16 MHz domain).
reset_n  in  1  asynchronous active-low reset.
ph2_f  in  1  one-cycle strobe; starts a read sequence.
rom_sz  in  2  ROM size code: bit1 = 32K, bit0 = 16K-or-larger.
stdrom  in  1  standard ROM selected; forces A13 through.
drv_en  in  NDR  per-drive enable; 0 = drive held in reset.
drv_addr  in  NDR*AW  packed drive ROM addresses, drive 0 in LSBs.
rom_q  in  DW  shared ROM read data.
mem_a  out  AW  registered, masked shared-ROM address.
mem_rd  out  1  high in cycles where mem_a carries a valid slot address.
drv_data  out  NDR*DW  packed per-drive captured bytes.
drv_vld  out  NDR  one-cycle pulse when the drive's byte updates.
busy  out  1  sequence in progress.
overrun  out  1  sticky: ph2_f arrived while busy.
ovr_clr  in  1  synchronous clear of overrun.

Behaviour:
- Reset (async, reset_n=0):
  - mem_a=0, mem_rd=0, drv_data all bytes 0xFF, drv_vld=0, busy=0, overrun=0.
  - FSM goes to IDLE; the pipeline is flushed.
- FSM states are IDLE, ISSUE and DRAIN.
- IDLE:
  - On ph2_f, latch all drv_addr into a snapshot register and set slot=0.
  - Go to ISSUE; busy=1 from the next cycle.
- ISSUE, one slot per cycle:
  - mem_a <= {a[14]&rom_sz[1], a[13]&(rom_sz[0]|stdrom), a[12:0]} of snapshot[slot].
  - mem_rd <= 1.
  - Push slot index plus a sequence tag into an RD_LAT-deep pipeline.
  - After slot NDR-1, go to DRAIN.
- DRAIN: wait until the pipeline is empty, then go to IDLE; busy=0 in the cycle after the last capture.
- Capture:
  - When the pipeline output is valid and its tag equals the current tag, drv_data[slot] <= rom_q and drv_vld[slot] pulses for one cycle.
  - drv_data holds its value between captures.
- Latency: ph2_f at cycle T gives mem_a for slot i at T+1+i and drv_vld[i] at T+2+i+RD_LAT−1. Worst-case busy span is NDR+RD_LAT+1 cycles.
- Disabled drive (drv_en[i]=0): the slot is still issued, but no capture happens, drv_vld[i] stays 0 and drv_data[i] is unchanged (default build).
- ph2_f while busy:
  - overrun <= 1.
  - The sequence restarts from slot 0 with a fresh snapshot and an incremented tag.
  - Reads in flight carrying the old tag are discarded, with no drv_vld pulse.
- ph2_f and ovr_clr in the same cycle while busy: overrun ends at 1 (set wins).
- Slot counter and tag wrap modulo their widths; a 2-bit tag is sufficient.
- rom_sz and stdrom are sampled per slot at issue time, not snapshotted.

Optional Feature:
IECDRV_SKIP_IDLE_EN.
- Defined: ISSUE skips any slot whose drv_en bit, latched at ph2_f, is 0. Remaining slots are issued back-to-back in ascending drive order. If no drive is enabled, ph2_f does not leave IDLE and busy stays 0.
- Undefined: fixed NDR slots as described under Behaviour.

Test Plan:
- NDR=4, RD_LAT=1, rom_sz=2'b11, addresses 0x0001/0x2002/0x4003/0x7FFF, ROM model returning the low byte of the address; ph2_f at T -> mem_a = those values at T+1..T+4; drv_vld[i] at T+2+i; drv_data = 01,02,03,FF.
- rom_sz=2'b00, stdrom=0, drv_addr[0]=0x7ABC -> mem_a=0x1ABC; with stdrom=1 -> mem_a=0x3ABC.
- drv_en=4'b1011 (drive 2 off), default build -> drv_vld[2] never pulses and drv_data[2] stays 0xFF; mem_rd is still high for 4 cycles. With IECDRV_SKIP_IDLE_EN -> mem_rd is high for 3 cycles.
- ph2_f at T and again at T+2, RD_LAT=2 -> overrun=1; no drv_vld pulse from the first sequence after T+2; four pulses from the second; ovr_clr -> overrun=0.
- reset_n low mid-ISSUE (asynchronous, between clk edges) -> all outputs return to reset values immediately; the first ph2_f after release runs a full clean sequence.
- RD_LAT=3, NDR=1, ph2_f at T -> mem_a at T+1, drv_vld[0] at T+4, busy falls at T+5.
